// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALUOp classes, the control bundle, and
// the rs1/rs2 usage decode that the hazard unit relies on.
package rv32i_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10,
        ALUOP_UPPER  = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   RegWrite;
        logic   MemRead;
        logic   MemWrite;
        logic   MemToReg;
        logic   ALUSrc;
        logic   Branch;
        logic   Jump;
        aluop_e ALUOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{default: '0, ALUOp: ALUOP_ADD};

    // U-type and JAL carry immediate bits where rs1 would be, so they read no rs1.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL:                         uses_rs1 = 1'b0;
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: uses_rs1 = 1'b1;
            default:                                          uses_rs1 = 1'b1;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
            default:                   uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_id_ex_stage_if.sv
// ID-side instruction bundle into the ID/EX register and the registered EX-side
// copy coming out of it.
interface rv32i_id_ex_stage_if
    import rv32i_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic            id_valid;
    logic [6:0]      id_opcode;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [2:0]      id_funct3;
    logic            id_funct7b5;
    logic            id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg;
    logic            id_ALUSrc, id_Branch, id_Jump;
    logic [1:0]      id_ALUOp;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg;
    logic            ex_ALUSrc, ex_Branch, ex_Jump;
    logic [1:0]      ex_ALUOp;

    modport master (
        output id_valid, id_opcode, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
               id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg,
               id_ALUSrc, id_Branch, id_Jump, id_ALUOp,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5,
               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg,
               ex_ALUSrc, ex_Branch, ex_Jump, ex_ALUOp
    );

    modport slave (
        input  id_valid, id_opcode, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
               id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg,
               id_ALUSrc, id_Branch, id_Jump, id_ALUOp,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5,
               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg,
               ex_ALUSrc, ex_Branch, ex_Jump, ex_ALUOp
    );

endinterface

// File: rtl/rv32i_hazard_detect.sv
// Combinational load-use detector: a load in EX whose rd is actually read by
// the instruction in ID.
module rv32i_hazard_detect
    import rv32i_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_MemRead,
    input  logic [4:0] ex_rd,
    output logic       hz
);

    logic use1;
    logic use2;

    assign use1 = uses_rs1(id_opcode);
    assign use2 = uses_rs2(id_opcode);

    // x0 never carries a real dependency, so a load to x0 cannot stall.
    assign hz = ex_valid & ex_MemRead & id_valid & (ex_rd != 5'd0)
              & ((use1 & (ex_rd == id_rs1)) | (use2 & (ex_rd == id_rs2)));

endmodule

// File: rtl/rv32i_id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush squash,
// downstream hold, and saturating stall/flush counters.
module rv32i_id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    rv32i_id_ex_stage_if.slave bus,
    input  logic             ex_flush,
    input  logic             ex_hold,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             load_use_hazard,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic            ex_valid_q;
    logic [XLEN-1:0] ex_pc_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
    logic [4:0]      ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic [2:0]      ex_funct3_q;
    logic            ex_funct7b5_q;
    ctrl_t           ex_ctrl_q;
    ctrl_t           id_ctrl;
    logic            hz;

    always_comb begin
        id_ctrl          = CTRL_NOP;
        id_ctrl.RegWrite = bus.id_RegWrite;
        id_ctrl.MemRead  = bus.id_MemRead;
        id_ctrl.MemWrite = bus.id_MemWrite;
        id_ctrl.MemToReg = bus.id_MemToReg;
        id_ctrl.ALUSrc   = bus.id_ALUSrc;
        id_ctrl.Branch   = bus.id_Branch;
        id_ctrl.Jump     = bus.id_Jump;
        id_ctrl.ALUOp    = aluop_e'(bus.id_ALUOp);
    end

    rv32i_hazard_detect u_hazard (
        .id_valid   (bus.id_valid),
        .id_opcode  (bus.id_opcode),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .ex_valid   (ex_valid_q),
        .ex_MemRead (ex_ctrl_q.MemRead),
        .ex_rd      (ex_rd_q),
        .hz         (hz)
    );

    // A flush throws the ID instruction away upstream, so it must not also stall.
    assign load_use_hazard = hz & ~ex_flush;
    assign pc_write_en     = ~(load_use_hazard | (ex_hold & ~ex_flush));
    assign if_id_write_en  = pc_write_en;

    // Priority: flush bubble, then hold, then load-use bubble, then normal load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || ex_flush || (!ex_hold && load_use_hazard)) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_funct3_q   <= '0;
            ex_funct7b5_q <= 1'b0;
            ex_ctrl_q     <= CTRL_NOP;
        end else if (!ex_hold) begin
            ex_valid_q    <= bus.id_valid;
            ex_pc_q       <= bus.id_pc;
            ex_rs1_data_q <= bus.id_rs1_data;
            ex_rs2_data_q <= bus.id_rs2_data;
            ex_imm_q      <= bus.id_imm;
            ex_rs1_q      <= bus.id_rs1;
            ex_rs2_q      <= bus.id_rs2;
            ex_rd_q       <= bus.id_rd;
            ex_funct3_q   <= bus.id_funct3;
            ex_funct7b5_q <= bus.id_funct7b5;
            ex_ctrl_q     <= bus.id_valid ? id_ctrl : CTRL_NOP;
        end
    end

    // Counters stick at all-ones rather than wrapping back to a misleading small value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (load_use_hazard && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ex_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_rs1_data = ex_rs1_data_q;
    assign bus.ex_rs2_data = ex_rs2_data_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rs1      = ex_rs1_q;
    assign bus.ex_rs2      = ex_rs2_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_funct3   = ex_funct3_q;
    assign bus.ex_funct7b5 = ex_funct7b5_q;
    assign bus.ex_RegWrite = ex_ctrl_q.RegWrite;
    assign bus.ex_MemRead  = ex_ctrl_q.MemRead;
    assign bus.ex_MemWrite = ex_ctrl_q.MemWrite;
    assign bus.ex_MemToReg = ex_ctrl_q.MemToReg;
    assign bus.ex_ALUSrc   = ex_ctrl_q.ALUSrc;
    assign bus.ex_Branch   = ex_ctrl_q.Branch;
    assign bus.ex_Jump     = ex_ctrl_q.Jump;
    assign bus.ex_ALUOp    = ex_ctrl_q.ALUOp;

endmodule
